// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x4 matrix keypad front end.
// Drives one column low at a time, samples the synchronised rows, builds a
// 16-bit frame of pressed keys and debounces single-key frames into a key
// code, a one-clock strobe and a held flag. Multi-key frames count as no key.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat strobes while held).
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [3:0] keypadRow,
  output logic [3:0] keypadCol,
  output logic [3:0] keypadButton,
  output logic       keyStrobe,
  output logic       keyHeld
);

  localparam int SCW = $clog2(SCAN_CYCLES);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DBW-1:0] DEB_FINAL = DBW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_e;

  logic [1:0]     rstSync_q;
  logic           rstN;
  logic [3:0]     rowMeta_q, rowSync_q;
  logic [1:0]     colIdx_q, colIdx_d;
  logic [SCW-1:0] scanCnt_q, scanCnt_d;
  logic [3:0]     keypadCol_q, keypadCol_d;
  logic [15:0]    accum_q, accum_d;
  logic [15:0]    sampleBits, frameMask;
  logic           sampleEdge, evalEdge;
  logic [4:0]     keyCount;
  logic [3:0]     keyCode;
  logic           isSingle;
  state_e         state_q, state_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic [3:0]     cand_q, cand_d;
  logic [3:0]     button_q, button_d;
  logic           strobe_q, strobe_d;
  logic           held_q, held_d;
  logic           accept;
  logic           repeatFire;

  // Reset synchroniser: assertion is immediate, release waits two clocks
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) rstSync_q <= 2'b00;
    else         rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstN = rstSync_q[1];

  // Scan datapath next-state: column timing, current column's keys, frame accumulator
  always_comb begin
    sampleEdge = (scanCnt_q == SCAN_LAST);
    evalEdge   = sampleEdge && (colIdx_q == 2'd3);
    sampleBits = '0;
    for (int r = 0; r < 4; r++) begin
      sampleBits[{2'(r), colIdx_q}] = ~rowSync_q[2'(r)];
    end
    frameMask   = accum_q | sampleBits;
    scanCnt_d   = sampleEdge ? '0 : scanCnt_q + SCW'(1);
    colIdx_d    = sampleEdge ? colIdx_q + 2'd1 : colIdx_q;
    keypadCol_d = ~(4'b0001 << colIdx_d);
    accum_d     = accum_q;
    if (sampleEdge) accum_d = (colIdx_q == 2'd3) ? '0 : frameMask;
  end

  // Frame classification: count pressed keys and remember which one
  always_comb begin
    keyCount = '0;
    keyCode  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frameMask[4'(i)]) begin
        keyCount = keyCount + 5'd1;
        keyCode  = 4'(i);
      end
    end
    isSingle = (keyCount == 5'd1);
  end

  // State register: scanner, synchroniser, debounce FSM and registered outputs
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      rowMeta_q   <= 4'hF;
      rowSync_q   <= 4'hF;
      colIdx_q    <= 2'd0;
      scanCnt_q   <= '0;
      keypadCol_q <= 4'b1110;
      accum_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      button_q    <= '0;
      strobe_q    <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      rowMeta_q   <= keypadRow;
      rowSync_q   <= rowMeta_q;
      colIdx_q    <= colIdx_d;
      scanCnt_q   <= scanCnt_d;
      keypadCol_q <= keypadCol_d;
      accum_q     <= accum_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      button_q    <= button_d;
      strobe_q    <= strobe_d;
      held_q      <= held_d;
    end
  end

  // Next-state logic: debounce transitions happen only on the frame-evaluation edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (evalEdge) begin
      case (state_q)
        IDLE: begin
          if (isSingle) begin
            cand_d  = keyCode;
            cnt_d   = DBW'(1);
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (isSingle && keyCode == cand_q) begin
            if (cnt_q == DEB_FINAL) begin
              state_d = PRESSED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + DBW'(1);
            end
          end else if (isSingle) begin
            cand_d = keyCode;
            cnt_d  = DBW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (!(isSingle && keyCode == button_q)) begin
            state_d = DEB_RELEASE;
            cnt_d   = DBW'(1);
          end
        end
        DEB_RELEASE: begin
          if (isSingle && keyCode == button_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_FINAL) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPW-1:0] REP_FINAL = RPW'(REPEAT_SCANS - 1);
  logic [RPW-1:0] repCnt_q, repCnt_d;

  // Repeat frame counter: only runs while staying in PRESSED, cleared otherwise
  always_comb begin
    repCnt_d   = repCnt_q;
    repeatFire = 1'b0;
    if (state_q != PRESSED || state_d != PRESSED) begin
      repCnt_d = '0;
    end else if (evalEdge) begin
      if (repCnt_q == REP_FINAL) begin
        repCnt_d   = '0;
        repeatFire = 1'b1;
      end else begin
        repCnt_d = repCnt_q + RPW'(1);
      end
    end
  end

  // Repeat counter register
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) repCnt_q <= '0;
    else       repCnt_q <= repCnt_d;
  end
`else
  assign repeatFire = 1'b0;
`endif

  // Output logic: code latches only on acceptance, held follows the pressed states
  always_comb begin
    accept   = evalEdge && (state_q == DEB_PRESS) && (state_d == PRESSED);
    button_d = accept ? cand_q : button_q;
    strobe_d = accept | repeatFire;
    held_d   = (state_d == PRESSED) || (state_d == DEB_RELEASE);
  end

  assign keypadCol    = keypadCol_q;
  assign keypadButton = button_q;
  assign keyStrobe    = strobe_q;
  assign keyHeld      = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a small
// keypad model (pressed-key mask shorted onto the driven column).
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       resetN;
  logic [3:0] keypadRow;
  logic [3:0] keypadCol;
  logic [3:0] keypadButton;
  logic       keyStrobe;
  logic       keyHeld;
  logic [15:0] keys;

  int total = 0;
  int bad = 0;
  logic [3:0] expQ[$];

  localparam logic [15:0] KEY9 = 16'h0200;
  localparam logic [15:0] KEY0 = 16'h0001;
  localparam logic [15:0] KEY5 = 16'h0020;

  keypad_scanner #(
    .SCAN_CYCLES(8),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(4)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .keypadRow(keypadRow),
    .keypadCol(keypadCol),
    .keypadButton(keypadButton),
    .keyStrobe(keyStrobe),
    .keyHeld(keyHeld)
  );

  always #5 clock = ~clock;

  // Keypad model: a row reads low when a pressed key sits on a driven column
  assign keypadRow[0] = ~|(keys[3:0]   & ~keypadCol);
  assign keypadRow[1] = ~|(keys[7:4]   & ~keypadCol);
  assign keypadRow[2] = ~|(keys[11:8]  & ~keypadCol);
  assign keypadRow[3] = ~|(keys[15:12] & ~keypadCol);

  // Monitor: every strobe must match the next expected key code
  always @(negedge clock) begin
    if (keyStrobe === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_strobe: got strobe with code %0d, expected no strobe", keypadButton);
      end else begin
        logic [3:0] e;
        e = expQ.pop_front();
        if (keypadButton !== e) begin
          bad++;
          $display("[TB] FAIL strobe_code: got %0d, expected %0d", keypadButton, e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Returns 1ns after the clock edge where column 0 is driven again after column 3
  task automatic waitFrameStart();
    logic [3:0] prevCol;
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      prevCol = keypadCol;
      @(posedge clock);
      #1;
      if (prevCol == 4'b0111 && keypadCol == 4'b1110) found = 1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("[TB] FAIL frame_start_timeout: got no frame start, expected one within 200 clocks");
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] expCol;
    keys = '0;
    resetN = 1'b0;
    waitClocks(4);
    $display("[TB] reset state");
    checkOutput("reset_col", keypadCol, 4'b1110);
    checkOutput("reset_button", keypadButton, 4'd0);
    checkOutput("reset_strobe", keyStrobe, 1'b0);
    checkOutput("reset_held", keyHeld, 1'b0);
    resetN = 1'b1;

    $display("[TB] column scan");
    waitFrameStart();
    for (int k = 1; k <= 4; k++) begin
      waitClocks(8);
      expCol = ~(4'b0001 << (k % 4));
      checkOutput("col_step", keypadCol, expCol);
    end

    $display("[TB] clean press of key 9");
    waitFrameStart();
    applyStimulus(KEY9);
    expQ.push_back(4'd9);
    waitClocks(80);
    checkOutput("press_not_early", expQ.size(), 1);
    waitClocks(32);
    checkOutput("press_strobe_seen", expQ.size(), 0);
    checkOutput("press_button", keypadButton, 4'd9);
    checkOutput("press_held", keyHeld, 1'b1);
    waitClocks(10 * 32);
    checkOutput("hold_held", keyHeld, 1'b1);

    $display("[TB] one-frame glitch then release");
    waitFrameStart();
    applyStimulus('0);
    waitClocks(32);
    applyStimulus(KEY9);
    waitClocks(3 * 32);
    checkOutput("glitch_held", keyHeld, 1'b1);
    waitFrameStart();
    applyStimulus('0);
    waitClocks(72);
    checkOutput("release_not_early", keyHeld, 1'b1);
    waitClocks(32);
    checkOutput("release_held", keyHeld, 1'b0);
    checkOutput("release_button", keypadButton, 4'd9);

    $display("[TB] bounce on key 9");
    waitFrameStart();
    waitClocks(8);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? KEY9 : 16'h0000);
      waitClocks(20);
    end
    applyStimulus(KEY9);
    expQ.push_back(4'd9);
    waitClocks(64);
    checkOutput("bounce_not_early", expQ.size(), 1);
    waitClocks(64);
    checkOutput("bounce_strobe_seen", expQ.size(), 0);
    checkOutput("bounce_held", keyHeld, 1'b1);

    $display("[TB] ghosting keys 0 and 5");
    applyStimulus('0);
    waitClocks(5 * 32);
    checkOutput("ghost_pre_idle", keyHeld, 1'b0);
    waitFrameStart();
    applyStimulus(KEY0 | KEY5);
    waitClocks(5 * 32);
    checkOutput("ghost_held", keyHeld, 1'b0);
    waitFrameStart();
    applyStimulus(KEY0);
    expQ.push_back(4'd0);
    waitClocks(80);
    checkOutput("ghost_not_early", expQ.size(), 1);
    waitClocks(48);
    checkOutput("ghost_strobe_seen", expQ.size(), 0);
    checkOutput("ghost_button", keypadButton, 4'd0);
    checkOutput("ghost_held_after", keyHeld, 1'b1);

    $display("[TB] reset during debounce");
    applyStimulus('0);
    waitClocks(5 * 32);
    waitFrameStart();
    applyStimulus(KEY9);
    waitClocks(42);
    resetN = 1'b0;
    #1;
    checkOutput("midrst_col", keypadCol, 4'b1110);
    checkOutput("midrst_button", keypadButton, 4'd0);
    checkOutput("midrst_strobe", keyStrobe, 1'b0);
    checkOutput("midrst_held", keyHeld, 1'b0);
    waitClocks(3);
    resetN = 1'b1;
    expQ.push_back(4'd9);
    waitClocks(80);
    checkOutput("midrst_not_early", expQ.size(), 1);
    waitClocks(48);
    checkOutput("midrst_strobe_seen", expQ.size(), 0);
    checkOutput("midrst_button_after", keypadButton, 4'd9);
    checkOutput("midrst_held_after", keyHeld, 1'b1);

`ifdef KEYPAD_AUTOREPEAT_EN
    $display("[TB] auto-repeat while holding key 9");
    for (int i = 0; i < 3; i++) expQ.push_back(4'd9);
    waitClocks(12 * 32 + 16);
    checkOutput("repeat_strobes_seen", expQ.size(), 0);
`endif

    waitClocks(8);
    checkOutput("final_queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
